// File: rtl/keypad_matrix_scanner_if.sv
// keypad_matrix_scanner_if: key event stream from the scanner FIFO to the consumer
interface keypad_matrix_scanner_if #(parameter int CODE_W = 5);
  logic [CODE_W-1:0] o_data;
  logic o_release;
  logic o_valid;
  logic i_ready;
  modport master (output o_data, o_release, o_valid, input i_ready);
  modport slave (input o_data, o_release, o_valid, output i_ready);
endinterface

// File: rtl/keypad_matrix_scanner.sv
// keypad_matrix_scanner: one-hot matrix scan plus aux pins, per-frame debounce, event FIFO.
// Define KEYPAD_RELEASE_EN to also queue release events.
module keypad_matrix_scanner #(
  parameter int N_ROWS = 4,
  parameter int N_COLS = 4,
  parameter int N_AUX = 6,
  parameter int SETTLE_CYCLES = 4,
  parameter int DEBOUNCE_FRAMES = 3,
  parameter int FIFO_DEPTH = 4,
  localparam int AW = N_AUX > 0 ? N_AUX : 1,
  localparam int NK = N_ROWS * N_COLS + N_AUX,
  localparam int CODE_W = $clog2(NK)
) (
  input  logic clk,
  input  logic rst,
  output logic [N_ROWS-1:0] o_word_lines,
  input  logic [N_COLS-1:0] i_bit_lines,
  input  logic [AW-1:0] i_aux,
  output logic o_overflow,
  input  logic i_clear_overflow,
  keypad_matrix_scanner_if.master evt
);
  localparam logic [1:0] SCAN = 2'd0;
  localparam logic [1:0] COMPARE = 2'd1;
  localparam logic [1:0] EMIT = 2'd2;
  localparam int RW = $clog2(N_ROWS);
  localparam int SW = $clog2(SETTLE_CYCLES);
  localparam int BW = $clog2(DEBOUNCE_FRAMES + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
`ifdef KEYPAD_RELEASE_EN
  localparam int EW = CODE_W + 1;
`else
  localparam int EW = CODE_W;
`endif
  logic [1:0] state_q, state_d;
  logic [RW-1:0] row_q, row_d;
  logic [SW-1:0] cnt_q, cnt_d;
  logic [NK-1:0] frame_q, frame_d, prev_q, prev_d, deb_q, deb_d, diff_q, diff_d;
  logic [BW-1:0] stable_q, stable_d;
  logic [CODE_W-1:0] idx_q, idx_d;
  logic primed_q, primed_d;
  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [PW:0] wp_q, rp_q;
  logic [EW-1:0] entry, head;
  logic push, pop, full, empty, wr;
  always_comb begin
    state_d = state_q;
    row_d = row_q;
    cnt_d = cnt_q;
    frame_d = frame_q;
    prev_d = prev_q;
    deb_d = deb_q;
    diff_d = diff_q;
    stable_d = stable_q;
    idx_d = idx_q;
    primed_d = primed_q;
    case (state_q)
      SCAN: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == SW'(SETTLE_CYCLES - 1)) begin
          cnt_d = '0;
          frame_d[int'(row_q) * N_COLS +: N_COLS] = i_bit_lines;
          row_d = row_q + 1'b1;
          if (row_q == RW'(N_ROWS - 1)) begin
            row_d = '0;
            state_d = COMPARE;
            for (int i = 0; i < N_AUX; i++) frame_d[N_ROWS * N_COLS + i] = i_aux[i];
          end
        end
      end
      COMPARE: begin
        // row 0 is already driven here, so this cycle counts toward its settle time
        state_d = SCAN;
        cnt_d = SW'(1);
        if (frame_q != prev_q) begin
          prev_d = frame_q;
          stable_d = '0;
        end else if (stable_q == BW'(DEBOUNCE_FRAMES - 1) && !primed_q) begin
          // first stable frame after reset is adopted silently: keys held through reset stay quiet
          primed_d = 1'b1;
          deb_d = frame_q;
          stable_d = stable_q + 1'b1;
        end else if (stable_q == BW'(DEBOUNCE_FRAMES - 1) && frame_q != deb_q) begin
          diff_d = frame_q ^ deb_q;
          deb_d = frame_q;
          idx_d = '0;
          cnt_d = '0;
          state_d = EMIT;
        end else begin
          stable_d = stable_q == BW'(DEBOUNCE_FRAMES) ? stable_q : stable_q + 1'b1;
        end
      end
      EMIT: begin
        idx_d = idx_q + 1'b1;
        cnt_d = '0;
        state_d = idx_q == CODE_W'(NK - 1) ? SCAN : EMIT;
      end
      default: state_d = SCAN;
    endcase
  end
`ifdef KEYPAD_RELEASE_EN
  assign push = state_q == EMIT && diff_q[idx_q];
  assign entry = {~deb_q[idx_q], idx_q};
  assign evt.o_release = head[CODE_W];
`else
  assign push = state_q == EMIT && diff_q[idx_q] && deb_q[idx_q];
  assign entry = idx_q;
  assign evt.o_release = 1'b0;
`endif
  assign empty = wp_q == rp_q;
  assign full = (wp_q ^ rp_q) == {1'b1, {PW{1'b0}}};
  assign pop = evt.o_valid && evt.i_ready;
  assign wr = push && (!full || pop);
  assign head = mem_q[rp_q[PW-1:0]];
  assign evt.o_valid = !empty;
  assign evt.o_data = head[CODE_W-1:0];
  assign o_word_lines = N_ROWS'(1) << row_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SCAN;
      row_q <= '0;
      cnt_q <= '0;
      frame_q <= '0;
      prev_q <= '0;
      deb_q <= '0;
      diff_q <= '0;
      stable_q <= '0;
      idx_q <= '0;
      primed_q <= 1'b0;
      wp_q <= '0;
      rp_q <= '0;
      o_overflow <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      row_q <= row_d;
      cnt_q <= cnt_d;
      frame_q <= frame_d;
      prev_q <= prev_d;
      deb_q <= deb_d;
      diff_q <= diff_d;
      stable_q <= stable_d;
      idx_q <= idx_d;
      primed_q <= primed_d;
      wp_q <= wp_q + (PW+1)'(wr);
      rp_q <= rp_q + (PW+1)'(pop);
      o_overflow <= (push && full && !pop) ? 1'b1 : i_clear_overflow ? 1'b0 : o_overflow;
      if (wr) mem_q[wp_q[PW-1:0]] <= entry;
    end
  end
endmodule

// File: doc/keypad_matrix_scanner.md
Name: keypad_matrix_scanner

Overview:
Parametrised keypad front end, successor to the fixed 4x4 button reader. Scans an N_ROWS x N_COLS matrix one-hot and samples N_AUX direct operator pins. Debounces all keys per frame and queues press events (and optionally release events) in a small FIFO. The FIFO drains to the calculator core over a valid/ready handshake.

Parameters:
N_ROWS, 4, word lines driven (>=2)
N_COLS, 4, bit lines read (>=1)
N_AUX, 6, direct pins (AC,+,-,*,/,=); 0 allowed
SETTLE_CYCLES, 4, clocks each word line is held before its bit lines are sampled (>=2)
DEBOUNCE_FRAMES, 3, consecutive identical frames needed to accept a change (>=1)
FIFO_DEPTH, 4, event queue entries (power of 2, >=2)
localparam CODE_W = clog2(N_ROWS*N_COLS+N_AUX)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
o_word_lines  out  N_ROWS  one-hot row drive, active-high
i_bit_lines  in  N_COLS  column sense, 1 = pressed
i_aux  in  N_AUX  direct pins, 1 = pressed
o_data  out  CODE_W  key code: row*N_COLS+col, or N_ROWS*N_COLS+aux index
o_release  out  1  1 = release event (0 when KEYPAD_RELEASE_EN is absent)
o_valid  out  1  FIFO head valid
i_ready  in  1  consumer accepts head
o_overflow  out  1  sticky: an event was dropped
i_clear_overflow  in  1  clears o_overflow

Behaviour:
- Single clock domain. Reset is synchronous and active-high, on port rst.
- Reset values: o_word_lines=1 (row 0), o_data=0, o_release=0, o_valid=0, o_overflow=0. Frame buffers, debounced state and stable counter are cleared (all keys released). FIFO is emptied and FSM goes to SCAN.
- Reset mid-operation discards pending events and any partial frame. No event is emitted for keys held through reset until they are released and pressed again.
- Each row is held for SETTLE_CYCLES. On the last cycle the bit lines are captured into the frame buffer for that row, then the row advances. A frame therefore takes N_ROWS*SETTLE_CYCLES clocks.
- FSM has three states: SCAN, COMPARE, EMIT.
- SCAN -> COMPARE after the last row is captured. i_aux is sampled in that same cycle.
- COMPARE takes 1 cycle:
  - If frame != previous frame: store it as previous, set stable=0, go to SCAN.
  - Else if stable+1 == DEBOUNCE_FRAMES and frame != debounced: set diff = frame ^ debounced, set debounced = frame, go to EMIT.
  - Else: increment stable, saturating at DEBOUNCE_FRAMES, and go to SCAN.
- EMIT walks key indices 0..N-1, one per clock, lowest first. For each set diff bit, if the key is now pressed it pushes a press event. With KEYPAD_RELEASE_EN defined it also pushes release events. Then EMIT -> SCAN, restarting at row 0. Word lines stay at row 0 during COMPARE and EMIT.
- FIFO is show-ahead: o_valid=1 whenever it is non-empty, and o_data/o_release reflect the head. Pop on o_valid&&i_ready. A push reaches the output one cycle after the write cycle.
- Push with pop in the same cycle while full: both happen and the push is accepted.
- Push while full without pop: the event is dropped and o_overflow is set. i_clear_overflow clears it; if a set and a clear land in the same cycle, set wins.
- o_data/o_release are held stable while o_valid && !i_ready.
- Ghosting (three or more keys forming a rectangle) is not resolved; raw matrix results are reported.

Optional Feature:
KEYPAD_RELEASE_EN
- Defined: a FIFO entry is CODE_W+1 bits wide. Releases are emitted with o_release=1, and for the same index the press is emitted before the release.
- Undefined: only presses are queued, the FIFO has no release bit, and o_release is tied to 0.

Test Plan:
All scenarios use default parameters; one frame is 16 clocks.
1. Reset release, no keys, i_ready=1 for 10 frames -> o_valid stays 0; o_word_lines cycles 1,2,4,8, each held 4 clocks.
2. Hold matrix row 2, col 1 (bit_lines[1]=1 while word_lines[2]=1) -> exactly one event with o_data=9 and o_release=0, valid within 4 frames plus 6+22 clocks.
3. Pulse i_aux[5] ('=') for 1 frame only -> no event. Hold it for 4 frames -> one event with o_data=21.
4. Hold i_ready=0 and create press events for key codes 0,1,2,3,4 -> the first 4 are queued in order and code 4 is dropped; o_overflow=1 until i_clear_overflow, then pops return 0,1,2,3.
5. Keys 3 and 16 become debounced in the same frame -> events arrive in order 3 then 16. Asserting rst while both are still held leaves o_valid=0 afterwards and produces no new events.
6. With KEYPAD_RELEASE_EN: press then release key 5 -> {5,release=0} then {5,release=1}. Without the macro: a single {5,release=0}.
